// File: rtl/miriscv_lsu_ctrl.sv
// Load-store controller: sequences one outstanding data-memory access, stalls the core while it
// is in flight, lays out store lanes and extends load data.
module miriscv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misalign_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i
);

  localparam logic [2:0] LdstB  = 3'd0;
  localparam logic [2:0] LdstH  = 3'd1;
  localparam logic [2:0] LdstW  = 3'd2;
  localparam logic [2:0] LdstBu = 3'd4;
  localparam logic [2:0] LdstHu = 3'd5;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      lane_q, lane_d;
  logic            req_d, we_d, fault_d;
  logic [3:0]      be_d, be_new;
  logic [31:0]     addr_d, wdata_d, data_d, wdata_new, rdata_sh, load_ext;
  logic            bad_access, go, timeout;

  always_comb begin
    case (lsu_size_i)
      LdstB, LdstBu: bad_access = 1'b0;
      LdstH, LdstHu: bad_access = lsu_addr_i[0];
      LdstW:         bad_access = |lsu_addr_i[1:0];
      default:       bad_access = 1'b1;
    endcase
  end

  assign lsu_misalign_o = lsu_req_i & bad_access;
  assign go             = lsu_req_i & ~bad_access;
  assign timeout        = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (lsu_size_i)
      LdstB, LdstBu: begin
        be_new    = 4'b0001 << lsu_addr_i[1:0];
        wdata_new = {4{lsu_data_i[7:0]}};
      end
      LdstH, LdstHu: begin
        be_new    = 4'b0011 << lsu_addr_i[1:0];
        wdata_new = {2{lsu_data_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = lsu_data_i;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 before extension.
  assign rdata_sh = data_rdata_i >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      LdstB:   load_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      LdstBu:  load_ext = {24'b0, rdata_sh[7:0]};
      LdstH:   load_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      LdstHu:  load_ext = {16'b0, rdata_sh[15:0]};
      default: load_ext = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (go) state_d = StWait;
      StWait:  if (data_ack_i || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lsu_stall_req_o = 1'b0;
    cnt_d   = cnt_q;
    size_d  = size_q;
    lane_d  = lane_q;
    req_d   = data_req_o;
    we_d    = data_we_o;
    be_d    = data_be_o;
    addr_d  = data_addr_o;
    wdata_d = data_wdata_o;
    data_d  = lsu_data_o;
    fault_d = lsu_fault_o;
    case (state_q)
      StIdle: begin
        lsu_stall_req_o = go;
        if (go) begin
          req_d   = 1'b1;
          we_d    = lsu_we_i;
          be_d    = be_new;
          addr_d  = {lsu_addr_i[31:2], 2'b00};
          wdata_d = wdata_new;
          size_d  = lsu_size_i;
          lane_d  = lsu_addr_i[1:0];
          cnt_d   = '0;
        end
      end
      StWait: begin
        lsu_stall_req_o = 1'b1;
        if (data_ack_i) begin
          req_d  = 1'b0;
          data_d = data_we_o ? 32'b0 : load_ext;
        end else if (timeout) begin
          req_d   = 1'b0;
          data_d  = 32'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  fault_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      size_q       <= '0;
      lane_q       <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      lsu_data_o   <= '0;
      lsu_fault_o  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      data_req_o   <= req_d;
      data_we_o    <= we_d;
      data_be_o    <= be_d;
      data_addr_o  <= addr_d;
      data_wdata_o <= wdata_d;
      lsu_data_o   <= data_d;
      lsu_fault_o  <= fault_d;
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_ctrl.sv
// Randomized bench for miriscv_lsu_ctrl against a transaction-level model of the access rules.
module tb_miriscv_lsu_ctrl;

  localparam int To = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, data_ack_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i, data_rdata_i;
  logic        lsu_stall_req_o, lsu_misalign_o, lsu_fault_o, data_req_o, data_we_o;
  logic [31:0] lsu_data_o, data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;

  int n_vec = 0;
  int n_err = 0;

  miriscv_lsu_ctrl #(.TIMEOUT_CYCLES(To)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_data_i     (lsu_data_i),
    .lsu_stall_req_o(lsu_stall_req_o),
    .lsu_data_o     (lsu_data_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_fault_o    (lsu_fault_o),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_rdata_i   (data_rdata_i),
    .data_ack_i     (data_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  // Model: access width in bytes, legality and alignment by modular arithmetic.
  function automatic int nbytes(input logic [2:0] size);
    case (size[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_mis(input logic [2:0] size, input logic [31:0] addr);
    bit legal = (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((addr % nbytes(size)) != 0);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] b = {24'b0, wd[7:0]};
    logic [31:0] h = {16'b0, wd[15:0]};
    case (nbytes(size))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] size, input int off,
                                             input logic [31:0] rd);
    int n = nbytes(size);
    longint unsigned v = longint'(rd) >> (8 * off);
    longint unsigned lim;
    if (n < 4) begin
      lim = 64'd1 << (8 * n);
      v   = v % lim;
      if (size < 3'd4 && v >= lim / 2) v = v + (64'd1 << 32) - lim;
    end
    return v[31:0];
  endfunction

  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                            input bit req_in_done, input bit drop_req);
    bit          mis = model_mis(size, addr);
    int          off = int'(addr % 4);
    int          n = nbytes(size);
    int          waits;
    bit          want_fault;
    logic [31:0] want_data, want_be, prev_data;
    int          req_cyc = 0;
    int          stall_cyc = 0;
    bit          acked = (ack_at >= 1 && ack_at <= To);

    waits      = acked ? ack_at : To;
    want_fault = !acked;
    want_data  = (!acked || we) ? 32'b0 : model_load(size, off, rd);
    want_be    = ((32'd1 << n) - 1) << off;
    prev_data  = lsu_data_o;

    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wd;
    data_ack_i = 1'($urandom_range(0, 1));
    #1;
    check_eq("misalign", {31'b0, lsu_misalign_o}, {31'b0, mis});
    if (mis) begin
      check_eq("stall_mis", {31'b0, lsu_stall_req_o}, 32'd0);
      @(posedge clk_i); #1;
      check_eq("req_mis", {31'b0, data_req_o}, 32'd0);
      check_eq("hold_mis", lsu_data_o, prev_data);
      lsu_req_i  = 1'b0;
      data_ack_i = 1'b0;
      return;
    end
    check_eq("stall_idle", {31'b0, lsu_stall_req_o}, 32'd1);
    @(posedge clk_i); #1;
    check_eq("req_start", {31'b0, data_req_o}, 32'd1);
    check_eq("we", {31'b0, data_we_o}, {31'b0, we});
    check_eq("be", {28'b0, data_be_o}, want_be);
    check_eq("addr", data_addr_o, addr - 32'(off));
    check_eq("wdata", data_wdata_o, model_wdata(size, wd));

    // Inputs are only sampled at the start edge; scramble them while the access is in flight.
    if (drop_req) lsu_req_i = 1'b0;
    lsu_we_i   = 1'($urandom);
    lsu_size_i = 3'($urandom);
    lsu_addr_i = $urandom;
    lsu_data_i = $urandom;
    for (int w = 1; w <= To + 2; w++) begin
      if (data_req_o) req_cyc++;
      if (lsu_stall_req_o) stall_cyc++;
      data_ack_i   = (w == ack_at);
      data_rdata_i = (w == ack_at) ? rd : $urandom;
      @(posedge clk_i); #1;
      if (!data_req_o) break;
    end
    check_eq("req_cycles", 32'(req_cyc), 32'(waits));
    check_eq("stall_cycles", 32'(stall_cyc + 1), 32'(waits + 1));

    lsu_req_i    = req_in_done;
    data_ack_i   = 1'($urandom_range(0, 1));
    data_rdata_i = $urandom;
    #1;
    check_eq("stall_done", {31'b0, lsu_stall_req_o}, 32'd0);
    check_eq("req_done", {31'b0, data_req_o}, 32'd0);
    check_eq("fault_done", {31'b0, lsu_fault_o}, {31'b0, want_fault});
    check_eq("data_done", lsu_data_o, want_data);
    @(posedge clk_i); #1;
    check_eq("req_after", {31'b0, data_req_o}, 32'd0);
    check_eq("fault_after", {31'b0, lsu_fault_o}, 32'd0);
    check_eq("data_hold", lsu_data_o, want_data);
    lsu_req_i  = 1'b0;
    data_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0; lsu_addr_i = '0;
    lsu_data_i = '0; data_rdata_i = '0; data_ack_i = 1'b0;
    #12;
    check_eq("rst_req", {31'b0, data_req_o}, 32'd0);
    check_eq("rst_data", lsu_data_o, 32'd0);
    check_eq("rst_fault", {31'b0, lsu_fault_o}, 32'd0);
    check_eq("rst_be", {28'b0, data_be_o}, 32'd0);
    check_eq("rst_stall", {31'b0, lsu_stall_req_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_access(1'b0, 3'd2, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_eq("lw_value", lsu_data_o, 32'hDEAD_BEEF);
    run_access(1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h8012_3456, 1'b0, 1'b0);
    check_eq("lb_value", lsu_data_o, 32'hFFFF_FF80);
    run_access(1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h8012_3456, 1'b0, 1'b0);
    check_eq("lbu_value", lsu_data_o, 32'h0000_0080);
    run_access(1'b0, 3'd5, 32'h102, 32'h0, 2, 32'h8012_3456, 1'b1, 1'b1);
    check_eq("lhu_value", lsu_data_o, 32'h0000_8012);
    run_access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 3, 32'h5555_5555, 1'b0, 1'b1);
    run_access(1'b0, 3'd2, 32'h101, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    run_access(1'b0, 3'd1, 32'h0FF, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    run_access(1'b0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    run_access(1'b0, 3'd2, 32'h104, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    run_access(1'b0, 3'd2, 32'h108, 32'h0, To, 32'hCAFE_F00D, 1'b1, 1'b0);
    check_eq("ack_at_timeout", lsu_data_o, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a wait.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h300;
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check_eq("arst_req", {31'b0, data_req_o}, 32'd0);
    check_eq("arst_addr", data_addr_o, 32'd0);
    check_eq("arst_data", lsu_data_o, 32'd0);
    check_eq("arst_stall", {31'b0, lsu_stall_req_o}, 32'd0);
    #2;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check_eq("arst_idle", {31'b0, data_req_o}, 32'd0);
    run_access(1'b0, 3'd2, 32'h400, 32'h0, 2, 32'h1357_9BDF, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      int r = int'($urandom_range(0, 9));
      int ack_at;
      logic [31:0] a = $urandom_range(0, 32'hFFFF);
      case (r)
        0:       ack_at = 0;
        1:       ack_at = To;
        2:       ack_at = To - 1;
        default: ack_at = int'($urandom_range(1, 4));
      endcase
      run_access(1'($urandom), 3'($urandom), a, $urandom, ack_at, $urandom,
                 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu_ctrl.md
Name: miriscv_lsu_ctrl

Overview:
Load-store controller sitting between the decoder/execute stage and the data-memory interface of the miriscv core.
- Takes the decoder's mem_req/mem_we/mem_size plus the ALU address and rs2 data.
- Sequences a single-outstanding memory transaction and freezes the core while it waits.
- Generates byte enables and the store-data lane layout, and sign- or zero-extends load data.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, maximum number of WAIT cycles without data_ack_i before the access is aborted (must be ≥2).

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset, asynchronous, active-high
lsu_req_i  in  1  memory access requested (decoder mem_req)
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
lsu_addr_i  in  32  byte address from ALU
lsu_data_i  in  32  store data (rs2)
lsu_stall_req_o  out  1  freeze PC/pipeline
lsu_data_o  out  32  extended load result
lsu_misalign_o  out  1  misaligned or illegal-size access
lsu_fault_o  out  1  bus timeout, one-cycle pulse
data_req_o  out  1  memory request
data_we_o  out  1  memory write
data_be_o  out  4  byte enables
data_addr_o  out  32  word address, bits [1:0] = 00
data_wdata_o  out  32  lane-replicated store data
data_rdata_i  in  32  memory read word
data_ack_i  in  1  transaction complete; read data valid in the same cycle

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- Reset (async, any state): state=IDLE, counter=0, and all registered outputs are 0 (data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_data_o, lsu_fault_o). data_req_o drops immediately on reset assertion.
- Misalign is combinational and only meaningful while lsu_req_i=1. It is set when any of these hold:
  - H/HU access with addr[0]=1;
  - W access with addr[1:0]≠0;
  - size ∈ {3,6,7}.
- On a misaligned access: lsu_misalign_o=1, stall=0, no memory request, FSM remains in IDLE.
- Stall is combinational: lsu_stall_req_o = (IDLE & lsu_req_i & ~misalign) | WAIT. It is 0 in DONE.
- IDLE → WAIT on an aligned lsu_req_i. On that edge the block captures:
  - data_addr_o = {addr[31:2], 2'b00};
  - data_we_o = lsu_we_i;
  - data_be_o: B/BU = 0001<<addr[1:0]; H/HU = 0011<<addr[1:0]; W = 1111;
  - data_wdata_o: B = {4{data[7:0]}}; H = {2{data[15:0]}}; W = data;
  - the size code and addr[1:0], kept internally;
  - data_req_o=1; counter cleared.
- WAIT, on data_ack_i=1: go to DONE and clear data_req_o.
  - Load: lsu_data_o = selected byte/halfword from data_rdata_i (lane = addr[1:0]), sign-extended for B/H, zero-extended for BU/HU; W passes through.
  - Store: lsu_data_o = 0.
- WAIT, no ack: counter increments. When the counter reaches TIMEOUT_CYCLES-1 with still no ack, go to DONE with data_req_o=0, lsu_data_o=0, lsu_fault_o=1.
- Ack in the same cycle as the timeout: ack wins, no fault.
- DONE lasts exactly one cycle, then → IDLE. lsu_fault_o clears on leaving DONE. lsu_data_o holds its value until the next completion.
- Latency: aligned access acked in its first WAIT cycle gives 2 stall cycles. Each additional WAIT cycle adds 1.
- data_req_o is high exactly for the WAIT cycles. Inputs are sampled only on the IDLE→WAIT edge.
- lsu_req_i deasserting during WAIT does not abort: the transaction completes.
- data_ack_i in IDLE or DONE is ignored.
- lsu_req_i=1 during DONE does not start a new access. The core has advanced by then, and the next request is seen in IDLE.
- Back-to-back requests therefore leave a minimum of one non-stalled cycle between accesses.

Test Plan:
1. LW addr 0x100, ack in first WAIT cycle, rdata 0xDEADBEEF -> data_req_o high 1 cycle, be=1111, data_addr_o=0x100, stall 2 cycles, lsu_data_o=0xDEADBEEF in DONE.
2. LB addr 0x103, rdata 0x80123456 -> be=1000, lsu_data_o=0xFFFFFF80; same with LBU -> 0x00000080; LHU addr 0x102 -> 0x00008012.
3. SH addr 0x202, data 0x1234ABCD, ack after 3 WAIT cycles -> we=1, be=1100, wdata=0xABCDABCD, addr 0x200, stall 4 cycles, lsu_data_o=0.
4. LW addr 0x101; then LH addr 0x0FF; then size=3 -> lsu_misalign_o=1 each time, stall=0, data_req_o never asserted.
5. LW with no ack, TIMEOUT_CYCLES=16 -> data_req_o high 16 cycles, then DONE with lsu_fault_o=1 for 1 cycle, lsu_data_o=0, stall released. Repeat with ack in cycle 16 -> no fault, data captured.
6. rst_i pulsed asynchronously mid-WAIT -> data_req_o=0 without waiting for a clock edge, all outputs zero, FSM in IDLE; a following LW completes normally.
